// File: rtl/md_pkg.sv
// md_pkg: shared multiply/divide op encodings and FSM state encoding for the MD unit and the decoder.
package md_pkg;
  localparam logic [2:0] MD_MULTU = 3'b000;
  localparam logic [2:0] MD_MULT  = 3'b001;
  localparam logic [2:0] MD_DIVU  = 3'b010;
  localparam logic [2:0] MD_DIV   = 3'b011;
  localparam logic [2:0] MD_MADD  = 3'b100;
  localparam logic [2:0] MD_MSUB  = 3'b101;
  localparam logic [2:0] MD_MADDU = 3'b110;
  localparam logic [2:0] MD_MSUBU = 3'b111;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} md_state_t;
  function automatic logic md_is_div(input logic [2:0] op);
    return op[2:1] == 2'b01;
  endfunction
  function automatic logic md_is_signed(input logic [2:0] op);
    return op == MD_MULT || op == MD_DIV || op == MD_MADD || op == MD_MSUB;
  endfunction
endpackage

// File: rtl/md_arith.sv
// md_arith: combinational multiply/accumulate/divide datapath producing the next HI/LO and a write enable.
module md_arith
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  output logic [WIDTH-1:0] o_hi_n,
  output logic [WIDTH-1:0] o_lo_n,
  output logic             o_wr_en
);
  localparam int W2 = 2 * WIDTH;
  logic w_sgn, w_div, w_bzero, w_ovf;
  logic [W2-1:0] w_ax, w_bx, w_prod, w_acc, w_mres;
  logic signed [WIDTH-1:0] w_sdvs, w_sq, w_sr;
  logic [WIDTH-1:0] w_udvs, w_uq, w_ur;
  assign w_sgn = md_is_signed(i_op);
  assign w_div = md_is_div(i_op);
  // sign-extending to 2*WIDTH makes one unsigned multiply serve both signednesses
  assign w_ax = w_sgn ? {{WIDTH{i_a[WIDTH-1]}}, i_a} : {{WIDTH{1'b0}}, i_a};
  assign w_bx = w_sgn ? {{WIDTH{i_b[WIDTH-1]}}, i_b} : {{WIDTH{1'b0}}, i_b};
  assign w_prod = w_ax * w_bx;
  assign w_acc = {i_hi, i_lo};
  assign w_mres = i_op[2] ? (i_op[0] ? w_acc - w_prod : w_acc + w_prod) : w_prod;
  assign w_bzero = i_b == '0;
  assign w_ovf = i_a == {1'b1, {(WIDTH-1){1'b0}}} && &i_b;
  // MIN / -1 divides by 1 instead: yields quotient MIN, remainder 0 with no overflow
  assign w_sdvs = (w_bzero || w_ovf) ? WIDTH'(1) : i_b;
  assign w_sq = $signed(i_a) / w_sdvs;
  assign w_sr = $signed(i_a) % w_sdvs;
  assign w_udvs = w_bzero ? WIDTH'(1) : i_b;
  assign w_uq = i_a / w_udvs;
  assign w_ur = i_a % w_udvs;
  assign o_hi_n = w_div ? (w_sgn ? w_sr : w_ur) : w_mres[W2-1:WIDTH];
  assign o_lo_n = w_div ? (w_sgn ? w_sq : w_uq) : w_mres[WIDTH-1:0];
  assign o_wr_en = !(w_div && w_bzero);
endmodule

// File: rtl/md_unit_param.sv
// md_unit_param: multi-cycle multiply/divide unit holding HI/LO, with parametrised width and latencies.
module md_unit_param
  import md_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       md_op,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic             cancel,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  md_state_t r_state, w_state_n;
  logic [CW-1:0] r_cnt;
  logic [2:0] r_op;
  logic [WIDTH-1:0] r_a, r_b, r_hi, r_lo, w_hi_n, w_lo_n;
  logic w_wr_en, w_accept, w_commit, w_move, w_last;
  md_arith #(.WIDTH(WIDTH)) u_arith (
    .i_op(r_op), .i_a(r_a), .i_b(r_b), .i_hi(r_hi), .i_lo(r_lo),
    .o_hi_n(w_hi_n), .o_lo_n(w_lo_n), .o_wr_en(w_wr_en)
  );
  assign w_last = r_cnt == CW'(1);
  assign w_accept = r_state == IDLE && start && !cancel;
  assign w_commit = r_state == BUSY && !cancel && w_last;
  assign w_move = r_state == IDLE && !start;
  always_comb begin
    w_state_n = r_state == IDLE ? (w_accept ? BUSY : IDLE) : ((cancel || w_last) ? IDLE : BUSY);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_state_n;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_op <= '0;
      r_a <= '0;
      r_b <= '0;
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      if (w_accept) begin
        r_cnt <= md_is_div(md_op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        r_op <= md_op;
        r_a <= rs_val;
        r_b <= rt_val;
      end else if (r_state == BUSY) r_cnt <= cancel ? '0 : r_cnt - CW'(1);
      if (w_commit && w_wr_en) begin
        r_hi <= w_hi_n;
        r_lo <= w_lo_n;
      end else if (w_move) begin
        if (mthi) r_hi <= rs_val;
        if (mtlo) r_lo <= rs_val;
      end
    end
  end
  assign busy = r_state == BUSY;
  assign hi = r_hi;
  assign lo = r_lo;
endmodule

// File: tb/tb_md_unit_param.sv
// tb_md_unit_param: directed plus randomized checks of md_unit_param against an integer-arithmetic model.
module tb_md_unit_param;
  logic clk = 0, reset_n = 0;
  always #5 clk = ~clk;
  logic start = 0, mthi = 0, mtlo = 0, cancel = 0, busy;
  logic [2:0] md_op = 0;
  logic [31:0] rs_val = 0, rt_val = 0, hi, lo;
  logic s16 = 0, busy16, z = 0;
  logic [2:0] op16 = 0;
  logic [15:0] a16 = 0, b16 = 0, hi16, lo16;
  int n_assert = 0, n_fail = 0;
  logic [31:0] m_hi = 0, m_lo = 0;
  logic [15:0] m16_hi = 0, m16_lo = 0;

  md_unit_param dut (
    .clk(clk), .reset_n(reset_n), .start(start), .md_op(md_op), .mthi(mthi), .mtlo(mtlo),
    .cancel(cancel), .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .hi(hi), .lo(lo)
  );
  md_unit_param #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(3)) dut16 (
    .clk(clk), .reset_n(reset_n), .start(s16), .md_op(op16), .mthi(z), .mtlo(z),
    .cancel(z), .rs_val(a16), .rt_val(b16), .busy(busy16), .hi(hi16), .lo(lo16)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // returns {write, hi, lo}; hi/lo zero-extended to 32 bits
  function automatic logic [64:0] model(input int w, input logic [2:0] op,
                                        input logic [31:0] a, b, h, l);
    longint mask, sa, sb, p, acc, res, q, r;
    bit sg;
    mask = (longint'(1) << w) - 1;
    sg = op inside {3'b001, 3'b011, 3'b100, 3'b101};
    sa = (sg && a[w-1]) ? longint'(a) - (longint'(1) << w) : longint'(a);
    sb = (sg && b[w-1]) ? longint'(b) - (longint'(1) << w) : longint'(b);
    if (op[2:1] == 2'b01) begin
      if (b == 0) return {1'b0, h, l};
      q = sa / sb;
      r = sa % sb;
      return {1'b1, 32'(r & mask), 32'(q & mask)};
    end
    p = sa * sb;
    acc = (longint'(h) << w) | longint'(l);
    res = (op[2] == 1'b0) ? p : (op[0] ? acc - p : acc + p);
    return {1'b1, 32'((res >> w) & mask), 32'(res & mask)};
  endfunction

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, b,
                       input int cancel_cyc, input bit hazard, input bit with_mv);
    logic [64:0] m;
    int cnt, exp_cyc;
    bit frozen;
    m = model(32, op, a, b, m_hi, m_lo);
    exp_cyc = cancel_cyc > 0 ? cancel_cyc : (op[2:1] == 2'b01 ? 10 : 5);
    @(negedge clk);
    start = 1; md_op = op; rs_val = a; rt_val = b; mtlo = with_mv;
    @(posedge clk); #1;
    start = 0; mtlo = 0; rs_val = $urandom; rt_val = $urandom;
    cnt = 0;
    frozen = 1;
    while (busy && cnt < 100) begin
      cnt++;
      if (hi !== m_hi || lo !== m_lo) frozen = 0;
      if (cnt == cancel_cyc) cancel = 1;
      if (hazard && cnt == 1) begin
        start = 1; mthi = 1; mtlo = 1; md_op = 3'($urandom);
      end
      @(posedge clk); #1;
      cancel = 0; start = 0; mthi = 0; mtlo = 0;
    end
    if (cancel_cyc == 0 && m[64]) begin
      m_hi = m[63:32];
      m_lo = m[31:0];
    end
    check("busy_cycles", 64'(cnt), 64'(exp_cyc));
    check("frozen_while_busy", {63'd0, frozen}, 64'd1);
    check("hi", {32'd0, hi}, {32'd0, m_hi});
    check("lo", {32'd0, lo}, {32'd0, m_lo});
  endtask

  task automatic mv(input bit h, input bit l, input logic [31:0] v);
    @(negedge clk);
    mthi = h; mtlo = l; rs_val = v;
    @(posedge clk); #1;
    mthi = 0; mtlo = 0;
    if (h) m_hi = v;
    if (l) m_lo = v;
    check("mv_hi", {32'd0, hi}, {32'd0, m_hi});
    check("mv_lo", {32'd0, lo}, {32'd0, m_lo});
  endtask

  task automatic do16(input logic [2:0] op, input logic [15:0] a, b);
    logic [64:0] m;
    int cnt;
    m = model(16, op, {16'd0, a}, {16'd0, b}, {16'd0, m16_hi}, {16'd0, m16_lo});
    @(negedge clk);
    s16 = 1; op16 = op; a16 = a; b16 = b;
    @(posedge clk); #1;
    s16 = 0; a16 = 16'($urandom); b16 = 16'($urandom);
    cnt = 0;
    while (busy16 && cnt < 100) begin
      cnt++;
      @(posedge clk); #1;
    end
    if (m[64]) begin
      m16_hi = m[47:32];
      m16_lo = m[15:0];
    end
    check("w16_busy_cycles", 64'(cnt), 64'(op[2:1] == 2'b01 ? 3 : 1));
    check("w16_hi", {48'd0, hi16}, {48'd0, m16_hi});
    check("w16_lo", {48'd0, lo16}, {48'd0, m16_lo});
  endtask

  initial begin
    int sel, cc;
    logic [31:0] ra, rb;
    #12;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    check("rst_busy16", {63'd0, busy16}, 64'd0);
    @(negedge clk);
    reset_n = 1;
    do_op(3'b001, 32'hFFFFFFFD, 32'd7, 0, 0, 0);
    check("t1_hi", {32'd0, hi}, 64'hFFFFFFFF);
    check("t1_lo", {32'd0, lo}, 64'hFFFFFFEB);
    mv(1, 0, 32'd0);
    mv(0, 1, 32'd10);
    do_op(3'b111, 32'd3, 32'd4, 0, 0, 0);
    check("t2_hi", {32'd0, hi}, 64'hFFFFFFFF);
    check("t2_lo", {32'd0, lo}, 64'hFFFFFFFE);
    do_op(3'b011, 32'hFFFFFFF9, 32'd2, 0, 0, 0);
    check("t3_lo", {32'd0, lo}, 64'hFFFFFFFD);
    check("t3_hi", {32'd0, hi}, 64'hFFFFFFFF);
    do_op(3'b011, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0);
    check("t3_ovf_lo", {32'd0, lo}, 64'h80000000);
    check("t3_ovf_hi", {32'd0, hi}, 64'd0);
    mv(1, 0, 32'd5);
    mv(0, 1, 32'd6);
    do_op(3'b010, 32'd123, 32'd0, 0, 0, 0);
    check("t4_hi", {32'd0, hi}, 64'd5);
    check("t4_lo", {32'd0, lo}, 64'd6);
    do_op(3'b000, 32'h1234, 32'h5678, 3, 0, 0);
    do_op(3'b100, 32'hDEADBEEF, 32'h0BADF00D, 0, 1, 0);
    do_op(3'b001, 32'h00012345, 32'hFFFF0001, 0, 0, 1);
    do_op(3'b101, 32'h7FFFFFFF, 32'h7FFFFFFF, 5, 0, 0);
    do_op(3'b011, 32'd1000, 32'd7, 10, 0, 0);
    mv(1, 1, 32'h55AA55AA);
    repeat (30) begin
      if ($urandom_range(0, 9) < 2) mv(1'($urandom), 1'($urandom), $urandom);
      else begin
        ra = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 20)) : $urandom;
        sel = $urandom_range(0, 5);
        rb = sel == 0 ? 32'd0 : sel == 1 ? 32'hFFFFFFFF : sel == 2 ? 32'($urandom_range(1, 9)) : $urandom;
        cc = $urandom_range(0, 5) == 0 ? $urandom_range(1, 5) : 0;
        do_op(3'($urandom), ra, rb, cc, (cc != 1) && ($urandom_range(0, 2) == 0), 1'($urandom));
      end
    end
    mv(1, 1, 32'hA5A5);
    @(negedge clk);
    start = 1; md_op = 3'b011; rs_val = 32'd100; rt_val = 32'd7;
    @(posedge clk); #1;
    start = 0;
    repeat (3) @(posedge clk);
    #3 reset_n = 0;
    #1;
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_hi", {32'd0, hi}, 64'd0);
    check("arst_lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    reset_n = 1;
    m_hi = 0;
    m_lo = 0;
    do_op(3'b110, 32'd100, 32'd7, 0, 0, 0);
    do16(3'b001, 16'hFFFD, 16'd7);
    check("w16_t1_hi", {48'd0, hi16}, 64'hFFFF);
    check("w16_t1_lo", {48'd0, lo16}, 64'hFFEB);
    repeat (10) do16(3'($urandom), 16'($urandom), $urandom_range(0, 3) == 0 ? 16'd0 : 16'($urandom));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
